// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator: selects a panel timing set from lcd_id and produces
// registered sync/enable/request strobes plus a gated pixel path.
module lcd_timing_gen #(
    parameter int unsigned POS_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      lcd_id,
    input  logic [15:0]      pixel_data,
    output logic             data_req,
    output logic [POS_W-1:0] pixel_xpos,
    output logic [POS_W-1:0] pixel_ypos,
    output logic [POS_W-1:0] h_disp,
    output logic [POS_W-1:0] v_disp,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic             lcd_bl,
    output logic [15:0]      lcd_rgb
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [POS_W-1:0] hs, hb, hd, hf;
        logic [POS_W-1:0] vs, vb, vd, vf;
    } timing_t;

    function automatic logic is_entry(input logic [15:0] id);
        return (id == 16'h4342) || (id == 16'h4384);
    endfunction

    function automatic timing_t lookup(input logic [15:0] id);
        timing_t t;
        t = '0;
        case (id)
            16'h4342: begin
                t.hs = POS_W'(41);  t.hb = POS_W'(2);  t.hd = POS_W'(480); t.hf = POS_W'(2);
                t.vs = POS_W'(10);  t.vb = POS_W'(2);  t.vd = POS_W'(272); t.vf = POS_W'(2);
            end
            16'h4384: begin
                t.hs = POS_W'(128); t.hb = POS_W'(88); t.hd = POS_W'(800); t.hf = POS_W'(40);
                t.vs = POS_W'(2);   t.vb = POS_W'(33); t.vd = POS_W'(480); t.vf = POS_W'(10);
            end
            default: t = '0;
        endcase
        return t;
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      cur_id_q, cur_id_d;
    logic [POS_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, req_q, req_d, bl_q, bl_d;
    logic [POS_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d, hdisp_q, hdisp_d, vdisp_q, vdisp_d;

    timing_t          cur_t;
    logic [POS_W-1:0] h_tot, v_tot, hsb, vsb;
    logic             run, vact;

    assign cur_t = lookup(cur_id_q);
    assign h_tot = cur_t.hs + cur_t.hb + cur_t.hd + cur_t.hf;
    assign v_tot = cur_t.vs + cur_t.vb + cur_t.vd + cur_t.vf;
    assign hsb   = cur_t.hs + cur_t.hb;
    assign vsb   = cur_t.vs + cur_t.vb;
    assign run   = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (is_entry(lcd_id)) begin
                    state_d  = RUN;
                    cur_id_d = lcd_id;
                end
            end
            RUN: begin
                if (!is_entry(lcd_id)) begin
                    state_d  = IDLE;
                    cur_id_d = '0;
                    h_cnt_d  = '0;
                    v_cnt_d  = '0;
                end else if (lcd_id != cur_id_q) begin
                    // Panel swapped on the fly: restart the frame under the new timing.
                    cur_id_d = lcd_id;
                    h_cnt_d  = '0;
                    v_cnt_d  = '0;
                end else if (h_cnt_q == h_tot - POS_W'(1)) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == v_tot - POS_W'(1)) ? '0 : v_cnt_q + POS_W'(1);
                end else begin
                    h_cnt_d = h_cnt_q + POS_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are derived from the current counters and land one cycle later.
    always_comb begin
        vact    = (v_cnt_q >= vsb) && (v_cnt_q < vsb + cur_t.vd);
        hs_d    = !(run && (h_cnt_q < cur_t.hs));
        vs_d    = !(run && (v_cnt_q < cur_t.vs));
        de_d    = run && vact && (h_cnt_q >= hsb) && (h_cnt_q < hsb + cur_t.hd);
        req_d   = run && vact && (h_cnt_q >= hsb - POS_W'(1))
                      && (h_cnt_q < hsb + cur_t.hd - POS_W'(1));
        xpos_d  = req_d ? h_cnt_q - (hsb - POS_W'(1)) : '0;
        ypos_d  = req_d ? v_cnt_q - vsb : '0;
        bl_d    = run;
        hdisp_d = run ? cur_t.hd : '0;
        vdisp_d = run ? cur_t.vd : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            req_q    <= 1'b0;
            bl_q     <= 1'b0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            hdisp_q  <= '0;
            vdisp_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            req_q    <= req_d;
            bl_q     <= bl_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            hdisp_q  <= hdisp_d;
            vdisp_q  <= vdisp_d;
        end
    end

    assign lcd_hs     = hs_q;
    assign lcd_vs     = vs_q;
    assign lcd_de     = de_q;
    assign data_req   = req_q;
    assign lcd_bl     = bl_q;
    assign pixel_xpos = xpos_q;
    assign pixel_ypos = ypos_q;
    assign h_disp     = hdisp_q;
    assign v_disp     = vdisp_q;
    assign lcd_rgb    = de_q ? pixel_data : '0;

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter: POS_W, 11, width of pixel_xpos / pixel_ypos / h_disp / v_disp.
REQ-002 Port: clk  in  1  pixel clock; all logic on its rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-high.
REQ-004 Port: lcd_id  in  16  panel ID from the ID-read stage; 0 means not yet known.
REQ-005 Port: pixel_data  in  16  RGB565 pixel from the frame source, valid one cycle after data_req.
REQ-006 Port: data_req  out  1  pixel request, leads lcd_de by exactly one cycle.
REQ-007 Port: pixel_xpos  out  POS_W  column of the requested pixel.
REQ-008 Port: pixel_ypos  out  POS_W  row of the requested pixel.
REQ-009 Port: h_disp  out  POS_W  active width of the selected panel (0 when idle).
REQ-010 Port: v_disp  out  POS_W  active height of the selected panel (0 when idle).
REQ-011 Port: lcd_hs  out  1  horizontal sync, active-low.
REQ-012 Port: lcd_vs  out  1  vertical sync, active-low.
REQ-013 Port: lcd_de  out  1  data enable.
REQ-014 Port: lcd_bl  out  1  backlight enable.
REQ-015 Port: lcd_rgb  out  16  pixel to the panel.

Function
REQ-016 Timing table (HS, HB, HD, HF / VS, VB, VD, VF), selected by lcd_id:
- 16'h4342: H = 41, 2, 480, 2 (total 525); V = 10, 2, 272, 2 (total 286).
- 16'h4384: H = 128, 88, 800, 40 (total 1056); V = 2, 33, 480, 10 (total 525).
REQ-017 Definitions: HSB = HS+HB; VSB = VS+VB.
REQ-018 FSM, state IDLE: entered from reset; stays while lcd_id is not a table entry; h_cnt = v_cnt = 0.
REQ-019 FSM, IDLE -> RUN: on the clock edge where lcd_id is a table entry; that ID is latched into cur_id.
REQ-020 FSM, RUN: h_cnt increments every cycle, wrapping at H_total-1 -> 0; v_cnt increments on that wrap, wrapping at V_total-1 -> 0.
REQ-021 FSM, first RUN cycle: h_cnt = 0, v_cnt = 0.
REQ-022 RUN, lcd_id changes to a different table entry: next cycle cur_id updates and both counters restart at 0.
REQ-023 RUN, lcd_id changes to a non-entry (including 0): return to IDLE next cycle.
REQ-024 Output registration: all outputs except lcd_rgb are registered from the counters of the previous cycle (one-cycle lag).
REQ-025 lcd_hs = 0 iff h_cnt < HS.
REQ-026 lcd_vs = 0 iff v_cnt < VS.
REQ-027 Line/row windows:
- vact = v_cnt in [VSB, VSB+VD).
- lcd_de = 1 iff vact and h_cnt in [HSB, HSB+HD).
- data_req = 1 iff vact and h_cnt in [HSB-1, HSB+HD-1).
REQ-028 Pixel position:
- pixel_xpos = h_cnt-(HSB-1) and pixel_ypos = v_cnt-VSB while data_req = 1.
- Both are 0 otherwise.
- Range: xpos 0..HD-1, ypos 0..VD-1.
REQ-029 lcd_rgb = pixel_data when lcd_de = 1, else 0 (combinational gate).
REQ-030 lcd_bl = 1 in RUN, 0 in IDLE.
REQ-031 h_disp / v_disp = HD / VD of cur_id in RUN, 0 in IDLE.
REQ-032 Counter arithmetic: all comparisons unsigned, 11-bit counters.
REQ-033 Counter ranges: no counter exceeds total-1; no wrap glitch on any output.

Reset
REQ-034 While rst = 1:
- State = IDLE; counters = 0; cur_id = 0.
- lcd_hs = lcd_vs = 1.
- lcd_de = data_req = lcd_bl = 0; lcd_rgb = 0.
- pixel_xpos = pixel_ypos = h_disp = v_disp = 0.
REQ-035 Reset asserted mid-frame: outputs reach the reset values immediately (asynchronously).
REQ-036 Reset release: FSM re-evaluates lcd_id on the first clock edge after release.

Verification
REQ-037 lcd_id = 16'h4342 held, release rst:
- lcd_hs low 41 of every 525 cycles.
- lcd_vs low 10 lines of every 286.
- 480 de cycles per active line; 272 active lines per frame.
- h_disp = 480, v_disp = 272.
REQ-038 lcd_id = 16'h4384:
- HS period 1056 with 128 low.
- 800x480 active area.
- First lcd_de rising edge 35*1056+216 cycles after the first RUN counter cycle, plus 1 cycle of output lag.
REQ-039 Every active line:
- data_req rises exactly one cycle before lcd_de and falls one cycle before it.
- pixel_xpos steps 0..HD-1 by 1.
- pixel_ypos is constant within a line.
REQ-040 pixel_data = {pixel_ypos[7:0], pixel_xpos[7:0]} returned one cycle after data_req: lcd_rgb matches that pattern whenever lcd_de = 1 and is 0 otherwise.
REQ-041 lcd_id = 0 for 100 cycles, then 16'h4342:
- lcd_bl = 0 and all syncs inactive while lcd_id = 0.
- RUN entered the edge after the change.
- lcd_id = 16'h1234: return to IDLE, lcd_bl = 0.
REQ-042 Reset mid-frame:
- rst asserted at h_cnt = 300, line 100: outputs go to reset values without waiting for a clock edge.
- After release: timing restarts from h_cnt = 0, v_cnt = 0.
